pwm_bank: RTL
=============

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 8: number of independent PWM channels, range 1..32.
REQ-002 Parameter CNT_WIDTH, default 16: width of the period counter, duty and phase values.
REQ-003 Parameter PRESC_WIDTH, default 16: width of the prescaler.
REQ-004 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  global run; 0 = counters held at 0, outputs at idle level.
REQ-007 period  in  CNT_WIDTH  shadow period; cycle length = period+1 ticks.
REQ-008 prescale  in  PRESC_WIDTH  tick every prescale+1 clocks; applied live, not shadowed.
REQ-009 cfg_wr_en  in  1  single-cycle strobe writing cfg_duty/cfg_phase to the shadow of channel cfg_ch.
REQ-010 cfg_ch  in  max(1,clog2(NUM_CH))  target channel index.
REQ-011 cfg_duty  in  CNT_WIDTH  shadow duty (high ticks per cycle).
REQ-012 cfg_phase  in  CNT_WIDTH  shadow phase offset in ticks.
REQ-013 ch_en  in  NUM_CH  per-channel enable, live.
REQ-014 invert  in  NUM_CH  per-channel output polarity, live.
REQ-015 update_req  in  1  request shadow-to-active transfer.
REQ-016 update_pending  out  1  transfer requested, not yet done.
REQ-017 pwm_out  out  NUM_CH  registered PWM outputs.
REQ-018 period_tick  out  1  one-cycle pulse per completed period.
REQ-019 counter  out  CNT_WIDTH  current period counter value.

Function
REQ-020 Prescaler: presc_cnt counts 0..prescale while enable=1; tick is asserted in the cycle presc_cnt==prescale, then presc_cnt goes to 0. prescale=0 gives a tick every clock. If prescale is lowered below presc_cnt, the next cycle wraps to 0 with a tick.
REQ-021 Counter: advances by 1 on each tick; on a tick with counter>=period_act it wraps to 0 (boundary event).
REQ-022 period_tick is registered: high for exactly one clock, the cycle after the boundary event (counter reads 0).
REQ-023 Per channel: pos = counter+phase_act, minus (period_act+1) if the sum exceeds period_act; the sum is computed CNT_WIDTH+1 bits wide; phase_act>period_act is treated as 0.
REQ-024 raw[i] = (pos < duty_act[i]): duty 0 gives constant low; duty > period_act gives constant high.
REQ-025 pwm_out[i] is registered, one clock after counter/pos: (enable & ch_en[i]) ? raw[i]^invert[i] : invert[i].
REQ-026 cfg_wr_en with cfg_ch>=NUM_CH is ignored; other shadows are unchanged.
REQ-027 The period input is sampled into the active period only at transfer.
REQ-028 Transfer copies all shadow duty/phase and period into the active registers atomically and clears update_pending.
REQ-029 With enable=1, update_req sets update_pending; transfer occurs at the next boundary event.
REQ-030 update_req asserted in the boundary cycle itself transfers at that boundary; update_pending stays 0.
REQ-031 With enable=0, update_req transfers on the next clock; update_pending is never set.
REQ-032 cfg_wr_en coincident with a transfer: the transfer uses the pre-write shadow value; the new value remains in the shadow.
REQ-033 Falling enable: presc_cnt and counter are synchronously cleared next clock; pwm_out goes to idle; a pending update is retained.
REQ-034 Rising enable: counting starts from counter=0 and presc_cnt=0.

Reset
REQ-035 Asynchronous reset: presc_cnt, counter, all shadow and active duty/phase/period = 0; update_pending = 0; period_tick = 0; pwm_out = 0 regardless of invert.
REQ-036 Reset deassertion mid-operation resumes from the REQ-035 state; the first pwm_out update follows the next clock edge.

Verification
REQ-037 Basic: prescale=0, period=9, ch0 duty=3, update_req with enable=0, then enable=1 -> pwm_out[0] high 3 clocks, low 7, repeating; period_tick every 10 clocks.
REQ-038 Phase/wrap: period=9, ch1 duty=3 phase=8 -> ch1 high when counter in {2,3,4}; phase=12 -> same as phase 0.
REQ-039 Limits: duty=0 -> constant 0; duty=10 with period=9 -> constant 1; invert=1 flips both; ch_en=0 -> output equals invert.
REQ-040 Glitch-free update: running with period=9; write duty=5, update_req at counter=4 -> update_pending=1 until wrap; new duty starts exactly at counter=0; update_req at the boundary cycle -> no pending.
REQ-041 Prescale/illegal index: prescale=3 -> counter advances every 4 clocks; cfg_wr_en with cfg_ch=NUM_CH -> no shadow changes.
REQ-042 Reset mid-period with invert=all ones -> pwm_out=0, counter=0, update_pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pwm_bank_if.sv
// pwm_bank_if: configuration, update handshake and output bundle of the PWM bank.
//
// master: drives enable, period, prescale, cfg_wr_en, cfg_ch, cfg_duty,
//         cfg_phase, ch_en, invert and update_req; observes the outputs.
// slave : the PWM bank; drives update_pending, pwm_out, period_tick and counter.
interface pwm_bank_if #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned PRESC_WIDTH = 16
) ();
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   enable;
    logic [CNT_WIDTH-1:0]   period;
    logic [PRESC_WIDTH-1:0] prescale;
    logic                   cfg_wr_en;
    logic [CH_W-1:0]        cfg_ch;
    logic [CNT_WIDTH-1:0]   cfg_duty;
    logic [CNT_WIDTH-1:0]   cfg_phase;
    logic [NUM_CH-1:0]      ch_en;
    logic [NUM_CH-1:0]      invert;
    logic                   update_req;
    logic                   update_pending;
    logic [NUM_CH-1:0]      pwm_out;
    logic                   period_tick;
    logic [CNT_WIDTH-1:0]   counter;

    modport master (
        output enable, period, prescale, cfg_wr_en, cfg_ch, cfg_duty, cfg_phase,
               ch_en, invert, update_req,
        input  update_pending, pwm_out, period_tick, counter
    );

    modport slave (
        input  enable, period, prescale, cfg_wr_en, cfg_ch, cfg_duty, cfg_phase,
               ch_en, invert, update_req,
        output update_pending, pwm_out, period_tick, counter
    );
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: NUM_CH phase-shifted PWM channels sharing one prescaled period
// counter. Duty, phase and period are double-buffered: software writes the
// shadow copies, and update_req moves them into the active copies at a period
// boundary so that no output ever sees a half-updated configuration.
//
// Ports:
//   S_AXI_ACLK     sole clock, rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   bus            pwm_bank_if.slave: enable, period, prescale, cfg_* shadow
//                  write port, ch_en, invert, update_req / update_pending,
//                  pwm_out, period_tick, counter
module pwm_bank #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic      S_AXI_ACLK,
    input  logic      S_AXI_ARESETN,
    pwm_bank_if.slave bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One bit wider than cfg_ch so NUM_CH itself is representable.
    localparam logic [CH_W:0]          CH_LIMIT  = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]     POS_ONE   = {{CNT_WIDTH{1'b0}}, 1'b1};
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESC_WIDTH-1:0] presc_cnt_r;
    logic [CNT_WIDTH-1:0]   counter_r;
    logic [CNT_WIDTH-1:0]   period_act_r;
    logic                   period_tick_r;
    logic                   update_pending_r;
    logic [NUM_CH-1:0]      pwm_out_r;
    logic [NUM_CH-1:0]      raw_s;

    logic                   tick_s;
    logic                   boundary_s;
    logic                   transfer_s;
    logic                   cfg_hit_s;

    logic [CNT_WIDTH-1:0]   duty_shd_r  [NUM_CH];
    logic [CNT_WIDTH-1:0]   phase_shd_r [NUM_CH];
    logic [CNT_WIDTH-1:0]   duty_act_r  [NUM_CH];
    logic [CNT_WIDTH-1:0]   phase_act_r [NUM_CH];

    // Tick, period boundary, shadow transfer and legal-write decode.
    always_comb begin
        tick_s     = 1'b0;
        boundary_s = 1'b0;
        transfer_s = 1'b0;
        cfg_hit_s  = 1'b0;
        if (bus.enable) begin
            // >= rather than == so a live prescale drop below the running
            // count wraps on the next cycle instead of running to overflow.
            tick_s     = (presc_cnt_r >= bus.prescale);
            boundary_s = tick_s && (counter_r >= period_act_r);
            transfer_s = boundary_s && (update_pending_r || bus.update_req);
        end else begin
            // While stopped there is no boundary to wait for.
            transfer_s = bus.update_req;
        end
        if ({1'b0, bus.cfg_ch} < CH_LIMIT) begin
            cfg_hit_s = bus.cfg_wr_en;
        end else begin
            cfg_hit_s = 1'b0;
        end
    end

    // Prescaler, period counter and the registered boundary pulse.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            presc_cnt_r   <= '0;
            counter_r     <= '0;
            period_tick_r <= 1'b0;
        end else if (!bus.enable) begin
            presc_cnt_r   <= '0;
            counter_r     <= '0;
            period_tick_r <= 1'b0;
        end else begin
            period_tick_r <= boundary_s;
            if (tick_s) begin
                presc_cnt_r <= '0;
                if (boundary_s) begin
                    counter_r <= '0;
                end else begin
                    counter_r <= counter_r + CNT_ONE;
                end
            end else begin
                presc_cnt_r <= presc_cnt_r + PRESC_ONE;
            end
        end
    end

    // Pending flag: only raised while running and the request missed a boundary.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            update_pending_r <= 1'b0;
        end else if (transfer_s) begin
            update_pending_r <= 1'b0;
        end else if (bus.enable && bus.update_req) begin
            update_pending_r <= 1'b1;
        end else begin
            update_pending_r <= update_pending_r;
        end
    end

    // Shadow registers; writes to channel indices beyond NUM_CH are dropped.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_shd_r[i]  <= '0;
                phase_shd_r[i] <= '0;
            end
        end else if (cfg_hit_s) begin
            duty_shd_r[bus.cfg_ch]  <= bus.cfg_duty;
            phase_shd_r[bus.cfg_ch] <= bus.cfg_phase;
        end
    end

    // Active registers; a coincident shadow write lands after this copy, so
    // the transfer carries the pre-write shadow value.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            period_act_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act_r[i]  <= '0;
                phase_act_r[i] <= '0;
            end
        end else if (transfer_s) begin
            period_act_r <= bus.period;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act_r[i]  <= duty_shd_r[i];
                phase_act_r[i] <= phase_shd_r[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] phase_eff_s;
        logic [CNT_WIDTH:0]   sum_s;
        logic [CNT_WIDTH:0]   pos_s;

        // Phase-shifted position folded back into 0..period_act.
        always_comb begin
            phase_eff_s = '0;
            sum_s       = '0;
            pos_s       = '0;
            if (phase_act_r[g] > period_act_r) begin
                phase_eff_s = '0;
            end else begin
                phase_eff_s = phase_act_r[g];
            end
            // Extra bit keeps counter+phase from wrapping at all-ones period.
            sum_s = {1'b0, counter_r} + {1'b0, phase_eff_s};
            if (sum_s > {1'b0, period_act_r}) begin
                pos_s = sum_s - ({1'b0, period_act_r} + POS_ONE);
            end else begin
                pos_s = sum_s;
            end
        end

        assign raw_s[g] = (pos_s < {1'b0, duty_act_r[g]});
    end

    // Output stage: disabled channels rest at their polarity level.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pwm_out_r <= '0;
        end else begin
            pwm_out_r <= (raw_s & bus.ch_en & {NUM_CH{bus.enable}}) ^ bus.invert;
        end
    end

    assign bus.counter        = counter_r;
    assign bus.period_tick    = period_tick_r;
    assign bus.update_pending = update_pending_r;
    assign bus.pwm_out        = pwm_out_r;
endmodule
